// File: rtl/dispatch_ctrl.sv
// Issue sequencer between the instruction decoder and the ROB/RS/LSB.
// Buffers one instruction while capacity is missing and stalls fetch across branches.
module dispatch_ctrl #(
    parameter int ROB_IDX_W   = 4,
    parameter int STALL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   dec_valid,
    input  logic [5:0]             dec_opcode,
    input  logic [6:0]             dec_ophead,
    input  logic [31:0]            dec_imm,
    input  logic [4:0]             dec_rs1,
    input  logic [4:0]             dec_rs2,
    input  logic [4:0]             dec_rd,
    input  logic                   rob_full,
    input  logic                   rs_full,
    input  logic                   lsb_full,
    input  logic                   br_resolve,
    input  logic                   flush,
    output logic                   if_stall,
    output logic                   iss_valid,
    output logic                   iss_to_rs,
    output logic                   iss_to_lsb,
    output logic [5:0]             iss_opcode,
    output logic [31:0]            iss_imm,
    output logic [4:0]             iss_rs1,
    output logic [4:0]             iss_rs2,
    output logic [4:0]             iss_rd,
    output logic [ROB_IDX_W-1:0]   iss_rob_idx,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_BR_WAIT = 2'd2
    } state_t;

    // Returns {to_rs, to_lsb}; load/store go to the LSB, LUI/AUIPC/JAL and illegal ops only need a ROB slot.
    function automatic logic [1:0] route_f(input logic [6:0] ophead, input logic [5:0] opcode);
        logic [1:0] r;
        if (ophead == 7'b0000011 || ophead == 7'b0100011) begin
            r = 2'b01;
        end else if (ophead == 7'b0110111 || ophead == 7'b0010111 ||
                     ophead == 7'b1101111 || opcode == 6'd0) begin
            r = 2'b00;
        end else begin
            r = 2'b10;
        end
        return r;
    endfunction

    function automatic logic is_branch_f(input logic [6:0] ophead);
        return (ophead == 7'b1100011) || (ophead == 7'b1100111);
    endfunction

    state_t                 state_r;
    logic [5:0]             buf_opcode_r;
    logic [31:0]            buf_imm_r;
    logic [4:0]             buf_rs1_r;
    logic [4:0]             buf_rs2_r;
    logic [4:0]             buf_rd_r;
    logic                   buf_to_rs_r;
    logic                   buf_to_lsb_r;
    logic                   buf_is_br_r;
    logic [ROB_IDX_W-1:0]   rob_cnt_r;
    logic [STALL_CNT_W-1:0] stall_cnt_r;

    logic                   iss_valid_r;
    logic                   iss_to_rs_r;
    logic                   iss_to_lsb_r;
    logic [5:0]             iss_opcode_r;
    logic [31:0]            iss_imm_r;
    logic [4:0]             iss_rs1_r;
    logic [4:0]             iss_rs2_r;
    logic [4:0]             iss_rd_r;
    logic [ROB_IDX_W-1:0]   iss_rob_idx_r;

    logic                   if_stall_s;
    logic                   accept_s;
    logic                   dec_to_rs_s;
    logic                   dec_to_lsb_s;
    logic                   sel_to_rs_s;
    logic                   sel_to_lsb_s;
    logic                   sel_is_br_s;
    logic [5:0]             sel_opcode_s;
    logic [31:0]            sel_imm_s;
    logic [4:0]             sel_rs1_s;
    logic [4:0]             sel_rs2_s;
    logic [4:0]             sel_rd_s;
    logic                   sel_free_s;
    logic                   issue_s;
    logic                   capture_s;

    // Fetch stall is a pure decode of the state register.
    always_comb begin
        if_stall_s = (state_r != ST_IDLE);
    end

    // Candidate instruction (buffer while holding, else decoder), its routing and issue/capture decision.
    always_comb begin
        {dec_to_rs_s, dec_to_lsb_s} = route_f(dec_ophead, dec_opcode);
        accept_s = dec_valid && !if_stall_s && rdy;
        if (state_r == ST_HOLD) begin
            sel_to_rs_s  = buf_to_rs_r;
            sel_to_lsb_s = buf_to_lsb_r;
            sel_is_br_s  = buf_is_br_r;
            sel_opcode_s = buf_opcode_r;
            sel_imm_s    = buf_imm_r;
            sel_rs1_s    = buf_rs1_r;
            sel_rs2_s    = buf_rs2_r;
            sel_rd_s     = buf_rd_r;
        end else begin
            sel_to_rs_s  = dec_to_rs_s;
            sel_to_lsb_s = dec_to_lsb_s;
            sel_is_br_s  = is_branch_f(dec_ophead);
            sel_opcode_s = dec_opcode;
            sel_imm_s    = dec_imm;
            sel_rs1_s    = dec_rs1;
            sel_rs2_s    = dec_rs2;
            sel_rd_s     = dec_rd;
        end
        sel_free_s = !rob_full && !(sel_to_rs_s && rs_full) && !(sel_to_lsb_s && lsb_full);
        if (rdy && !flush) begin
            issue_s   = ((state_r == ST_IDLE) && accept_s && sel_free_s) ||
                        ((state_r == ST_HOLD) && sel_free_s);
            capture_s = (state_r == ST_IDLE) && accept_s && !sel_free_s;
        end else begin
            issue_s   = 1'b0;
            capture_s = 1'b0;
        end
    end

    // Dispatch FSM with the buffer, ROB index counter, stall counter and registered issue outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            buf_opcode_r  <= 6'd0;
            buf_imm_r     <= 32'd0;
            buf_rs1_r     <= 5'd0;
            buf_rs2_r     <= 5'd0;
            buf_rd_r      <= 5'd0;
            buf_to_rs_r   <= 1'b0;
            buf_to_lsb_r  <= 1'b0;
            buf_is_br_r   <= 1'b0;
            rob_cnt_r     <= '0;
            stall_cnt_r   <= '0;
            iss_valid_r   <= 1'b0;
            iss_to_rs_r   <= 1'b0;
            iss_to_lsb_r  <= 1'b0;
            iss_opcode_r  <= 6'd0;
            iss_imm_r     <= 32'd0;
            iss_rs1_r     <= 5'd0;
            iss_rs2_r     <= 5'd0;
            iss_rd_r      <= 5'd0;
            iss_rob_idx_r <= '0;
        end else if (!rdy) begin
            iss_valid_r <= 1'b0;
        end else begin
            iss_valid_r <= issue_s;
            // Every enabled cycle spent in HOLD is counted, including one cut short by flush.
            if (state_r == ST_HOLD && stall_cnt_r != {STALL_CNT_W{1'b1}}) begin
                stall_cnt_r <= stall_cnt_r + STALL_CNT_W'(1);
            end
            if (flush) begin
                state_r       <= ST_IDLE;
                rob_cnt_r     <= '0;
                iss_rob_idx_r <= '0;
            end else if (issue_s) begin
                iss_to_rs_r   <= sel_to_rs_s;
                iss_to_lsb_r  <= sel_to_lsb_s;
                iss_opcode_r  <= sel_opcode_s;
                iss_imm_r     <= sel_imm_s;
                iss_rs1_r     <= sel_rs1_s;
                iss_rs2_r     <= sel_rs2_s;
                iss_rd_r      <= sel_rd_s;
                iss_rob_idx_r <= rob_cnt_r;
                rob_cnt_r     <= rob_cnt_r + ROB_IDX_W'(1);
                state_r       <= sel_is_br_s ? ST_BR_WAIT : ST_IDLE;
            end else if (capture_s) begin
                buf_opcode_r <= dec_opcode;
                buf_imm_r    <= dec_imm;
                buf_rs1_r    <= dec_rs1;
                buf_rs2_r    <= dec_rs2;
                buf_rd_r     <= dec_rd;
                buf_to_rs_r  <= dec_to_rs_s;
                buf_to_lsb_r <= dec_to_lsb_s;
                buf_is_br_r  <= is_branch_f(dec_ophead);
                state_r      <= ST_HOLD;
            end else begin
                case (state_r)
                    ST_IDLE:    state_r <= ST_IDLE;
                    ST_HOLD:    state_r <= ST_HOLD;
                    ST_BR_WAIT: state_r <= br_resolve ? ST_IDLE : ST_BR_WAIT;
                    default:    state_r <= ST_IDLE;
                endcase
            end
        end
    end

    assign if_stall     = if_stall_s;
    assign iss_valid    = iss_valid_r;
    assign iss_to_rs    = iss_to_rs_r;
    assign iss_to_lsb   = iss_to_lsb_r;
    assign iss_opcode   = iss_opcode_r;
    assign iss_imm      = iss_imm_r;
    assign iss_rs1      = iss_rs1_r;
    assign iss_rs2      = iss_rs2_r;
    assign iss_rd       = iss_rd_r;
    assign iss_rob_idx  = iss_rob_idx_r;
    assign stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Scoreboard bench for dispatch_ctrl: stimulus pushes expected issues, a negedge monitor pops and compares.
module tb_dispatch_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, dec_valid, rob_full, rs_full, lsb_full, br_resolve, flush;
    logic [5:0]  dec_opcode;
    logic [6:0]  dec_ophead;
    logic [31:0] dec_imm;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        if_stall, iss_valid, iss_to_rs, iss_to_lsb;
    logic [5:0]  iss_opcode;
    logic [31:0] iss_imm;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd;
    logic [3:0]  iss_rob_idx;
    logic [7:0]  stall_cycles;

    always #5 clk = ~clk;

    dispatch_ctrl #(.ROB_IDX_W(4), .STALL_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .dec_valid(dec_valid), .dec_opcode(dec_opcode),
        .dec_ophead(dec_ophead), .dec_imm(dec_imm), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rd(dec_rd), .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .br_resolve(br_resolve), .flush(flush), .if_stall(if_stall), .iss_valid(iss_valid),
        .iss_to_rs(iss_to_rs), .iss_to_lsb(iss_to_lsb), .iss_opcode(iss_opcode),
        .iss_imm(iss_imm), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
        .iss_rob_idx(iss_rob_idx), .stall_cycles(stall_cycles)
    );

    typedef struct packed {
        logic        to_rs;
        logic        to_lsb;
        logic [5:0]  opc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  idx;
    } exp_t;

    exp_t       q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [3:0] exp_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] oph, input logic [5:0] opc, input logic [31:0] imm,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        dec_valid  = 1'b1;
        dec_ophead = oph;
        dec_opcode = opc;
        dec_imm    = imm;
        dec_rs1    = r1;
        dec_rs2    = r2;
        dec_rd     = rd;
    endtask

    task automatic push(input logic trs, input logic tlsb, input logic [5:0] opc, input logic [31:0] imm,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        exp_t e;
        e = '{to_rs: trs, to_lsb: tlsb, opc: opc, imm: imm, rs1: r1, rs2: r2, rd: rd, idx: exp_idx};
        q.push_back(e);
        exp_idx = exp_idx + 4'd1;
    endtask

    // Monitor: every issue pulse must match the oldest expected issue.
    always @(negedge clk) begin
        if (rst === 1'b1 && iss_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_issue actual opcode=0x%0h idx=%0d expected no issue at %0t",
                         iss_opcode, iss_rob_idx, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("iss_to_rs", {31'd0, iss_to_rs}, {31'd0, e.to_rs});
                chk("iss_to_lsb", {31'd0, iss_to_lsb}, {31'd0, e.to_lsb});
                chk("iss_opcode", {26'd0, iss_opcode}, {26'd0, e.opc});
                chk("iss_imm", iss_imm, e.imm);
                chk("iss_regs", {17'd0, iss_rs1, iss_rs2, iss_rd}, {17'd0, e.rs1, e.rs2, e.rd});
                chk("iss_rob_idx", {28'd0, iss_rob_idx}, {28'd0, e.idx});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rdy = 1'b1; dec_valid = 1'b0; rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
        br_resolve = 1'b0; flush = 1'b0; dec_opcode = 6'd0; dec_ophead = 7'd0; dec_imm = 32'd0;
        dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0; exp_idx = 4'd0;
        step(2);
        chk("reset_iss_valid", {31'd0, iss_valid}, 32'd0);
        chk("reset_if_stall", {31'd0, if_stall}, 32'd0);
        chk("reset_stall_cycles", {24'd0, stall_cycles}, 32'd0);
        chk("reset_rob_idx", {28'd0, iss_rob_idx}, 32'd0);
        chk("reset_iss_imm", iss_imm, 32'd0);
        rst = 1'b1;
        step(1);

        // ADDI with everything free issues next cycle to RS with index 0
        push(1'b1, 1'b0, 6'd5, 32'h0000_0123, 5'd1, 5'd2, 5'd3);
        send(7'b0010011, 6'd5, 32'h0000_0123, 5'd1, 5'd2, 5'd3);
        step(1);
        dec_valid = 1'b0;
        chk("t1_iss_valid", {31'd0, iss_valid}, 32'd1);
        chk("t1_if_stall", {31'd0, if_stall}, 32'd0);
        step(1);

        // Routing: SW ignores rs_full, ADDI ignores lsb_full, LUI is ROB-only
        rs_full = 1'b1;
        push(1'b0, 1'b1, 6'd11, 32'h0000_0004, 5'd4, 5'd5, 5'd0);
        send(7'b0100011, 6'd11, 32'h0000_0004, 5'd4, 5'd5, 5'd0);
        step(1);
        rs_full = 1'b0; lsb_full = 1'b1;
        push(1'b1, 1'b0, 6'd6, 32'h0000_0FFF, 5'd9, 5'd0, 5'd10);
        send(7'b0010011, 6'd6, 32'h0000_0FFF, 5'd9, 5'd0, 5'd10);
        step(1);
        lsb_full = 1'b0;
        push(1'b0, 1'b0, 6'd12, 32'hABCD_E000, 5'd0, 5'd0, 5'd7);
        send(7'b0110111, 6'd12, 32'hABCD_E000, 5'd0, 5'd0, 5'd7);
        step(1);
        dec_valid = 1'b0;
        step(1);

        // LW held by lsb_full for three cycles, decoder input ignored while held
        lsb_full = 1'b1;
        send(7'b0000011, 6'd10, 32'h0000_0010, 5'd6, 5'd0, 5'd8);
        step(1);
        chk("t2_if_stall_h1", {31'd0, if_stall}, 32'd1);
        send(7'b0010011, 6'd63, 32'h0000_DEAD, 5'd1, 5'd1, 5'd1);
        step(1);
        chk("t2_if_stall_h2", {31'd0, if_stall}, 32'd1);
        step(1);
        dec_valid = 1'b0; lsb_full = 1'b0;
        push(1'b0, 1'b1, 6'd10, 32'h0000_0010, 5'd6, 5'd0, 5'd8);
        step(1);
        chk("t2_stall_cycles", {24'd0, stall_cycles}, 32'd3);
        chk("t2_if_stall_after", {31'd0, if_stall}, 32'd0);
        step(1);

        // BEQ stalls fetch until br_resolve
        push(1'b1, 1'b0, 6'd20, 32'hFFFF_FFF8, 5'd1, 5'd2, 5'd0);
        send(7'b1100011, 6'd20, 32'hFFFF_FFF8, 5'd1, 5'd2, 5'd0);
        step(1);
        chk("t3_if_stall", {31'd0, if_stall}, 32'd1);
        send(7'b0110011, 6'd1, 32'h0000_0BAD, 5'd3, 5'd3, 5'd3);
        step(3);
        chk("t3_if_stall_wait", {31'd0, if_stall}, 32'd1);
        dec_valid = 1'b0; br_resolve = 1'b1;
        step(1);
        br_resolve = 1'b0;
        chk("t3_if_stall_release", {31'd0, if_stall}, 32'd0);

        // Flush in IDLE restarts ROB indexing, then 17 back-to-back ADDs wrap the index
        flush = 1'b1;
        step(1);
        flush = 1'b0; exp_idx = 4'd0;
        chk("t4_flush_idx", {28'd0, iss_rob_idx}, 32'd0);
        for (int i = 0; i < 17; i++) begin
            push(1'b1, 1'b0, 6'd1, 32'(i), 5'(i), 5'(i + 1), 5'(i + 2));
            send(7'b0110011, 6'd1, 32'(i), 5'(i), 5'(i + 1), 5'(i + 2));
            step(1);
        end
        dec_valid = 1'b0;
        chk("t4_17th_valid", {31'd0, iss_valid}, 32'd1);
        chk("t4_17th_idx", {28'd0, iss_rob_idx}, 32'd0);
        step(1);

        // Flush while holding: buffered instruction dropped, same-cycle issue discarded
        rob_full = 1'b1;
        send(7'b0010011, 6'd2, 32'h0000_0002, 5'd2, 5'd2, 5'd2);
        step(1);
        dec_valid = 1'b0;
        step(1);
        rob_full = 1'b0; flush = 1'b1;
        step(1);
        flush = 1'b0; exp_idx = 4'd0;
        chk("t5_if_stall", {31'd0, if_stall}, 32'd0);
        chk("t5_iss_valid", {31'd0, iss_valid}, 32'd0);
        chk("t5_rob_idx", {28'd0, iss_rob_idx}, 32'd0);
        chk("t5_stall_cycles", {24'd0, stall_cycles}, 32'd5);
        push(1'b1, 1'b0, 6'd3, 32'h0000_0033, 5'd3, 5'd4, 5'd5);
        send(7'b0010011, 6'd3, 32'h0000_0033, 5'd3, 5'd4, 5'd5);
        step(1);
        dec_valid = 1'b0;
        step(1);

        // Asynchronous reset mid-HOLD clears outputs immediately
        rob_full = 1'b1;
        send(7'b0010011, 6'd4, 32'h0000_0044, 5'd4, 5'd4, 5'd4);
        step(1);
        dec_valid = 1'b0;
        step(1);
        #2 rst = 1'b0;
        #1;
        chk("t5r_if_stall", {31'd0, if_stall}, 32'd0);
        chk("t5r_iss_opcode", {26'd0, iss_opcode}, 32'd0);
        chk("t5r_iss_imm", iss_imm, 32'd0);
        chk("t5r_stall_cycles", {24'd0, stall_cycles}, 32'd0);
        rst = 1'b1; exp_idx = 4'd0;
        step(1);

        // rdy=0 while resources free up: frozen, flush ignored, issue on first enabled edge
        rob_full = 1'b1;
        send(7'b0010011, 6'd7, 32'h0000_0077, 5'd7, 5'd8, 5'd9);
        step(1);
        dec_valid = 1'b0;
        step(1);
        rdy = 1'b0; rob_full = 1'b0; flush = 1'b1;
        step(3);
        flush = 1'b0;
        chk("t6_stall_frozen", {24'd0, stall_cycles}, 32'd1);
        chk("t6_if_stall", {31'd0, if_stall}, 32'd1);
        chk("t6_no_issue", {31'd0, iss_valid}, 32'd0);
        rdy = 1'b1;
        push(1'b1, 1'b0, 6'd7, 32'h0000_0077, 5'd7, 5'd8, 5'd9);
        step(1);
        chk("t6_issue", {31'd0, iss_valid}, 32'd1);
        chk("t6_stall_cycles", {24'd0, stall_cycles}, 32'd2);
        chk("t6_if_stall_after", {31'd0, if_stall}, 32'd0);
        step(2);

        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
